// File: rtl/chunked_add_sub_pkg.sv
// Shared types and helpers for the chunked adder/subtractor.
package chunked_add_sub_pkg;

   // Controller states: idle/accepting, chunk processing, one-cycle completion.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of the chunk index; a single-chunk configuration still gets one bit.
   function automatic int idx_width(input int nchunk);
      if (nchunk <= 1) begin
         return 1;
      end
      return $clog2(nchunk);
   endfunction

endpackage

// File: rtl/chunked_add_sub_if.sv
// Request/response bundle between a controller and the chunked adder/subtractor.
interface chunked_add_sub_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             borrow;
   logic             overflow;

   // Controller side: issues operations, observes status and results.
   modport master (
      output start, sub, a, b,
      input  ready, done, result, borrow, overflow
   );

   // Arithmetic unit side.
   modport slave (
      input  start, sub, a, b,
      output ready, done, result, borrow, overflow
   );
endinterface

// File: rtl/chunked_add_sub_slice.sv
// CHUNK-bit add/subtract cell with borrow/carry in and out; the multi-bit
// generalisation of a full-subtractor/full-adder cell.
module chunk_add_sub_slice #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             mode,
   input  logic             bin,
   output logic [CHUNK-1:0] d,
   output logic             bout
);
   logic [CHUNK:0] wide;

   // One extra bit catches the carry (add) or the borrow (sub, result negative).
   always_comb begin
      wide = '0;
      if (mode) begin
         wide = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bin};
      end else begin
         wide = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, bin};
      end
      d    = wide[CHUNK-1:0];
      bout = wide[CHUNK];
   end

endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock,
// least-significant chunk first, with the borrow/carry registered between
// chunks. Results are held in output registers until the next completion.
module chunked_add_sub
   import chunked_add_sub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input logic              clk,
   input logic              rst,
   chunked_add_sub_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = idx_width(NCHUNK);

   generate
      if (WIDTH < 2) begin : g_bad_width
         $error("chunked_add_sub: WIDTH must be at least 2");
      end
      if (CHUNK < 1) begin : g_bad_chunk
         $error("chunked_add_sub: CHUNK must be at least 1");
      end else if ((WIDTH % CHUNK) != 0) begin : g_bad_ratio
         $error("chunked_add_sub: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             sub_reg;
   logic [IDXW-1:0]  idx;
   logic             bin;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;

   logic [WIDTH-1:0] res_reg;
   logic             brw_reg;
   logic             ovf_reg;

   logic             last;
   int               base;
   logic [CHUNK-1:0] slice_a;
   logic [CHUNK-1:0] slice_b;
   logic [CHUNK-1:0] slice_d;
   logic             slice_bout;

   // Two's-complement overflow from the operand and result sign bits.
   function automatic logic ovf_calc(input logic mode, input logic a_s,
                                     input logic b_s, input logic r_s);
      if (mode) begin
         return (a_s != b_s) && (r_s != a_s);
      end
      return (a_s == b_s) && (r_s != a_s);
   endfunction

   assign last = (int'(idx) == NCHUNK - 1);
   assign base = int'(idx) * CHUNK;

   // Select the operand chunks addressed by the current index.
   always_comb begin
      slice_a = a_reg[base +: CHUNK];
      slice_b = b_reg[base +: CHUNK];
   end

   chunk_add_sub_slice #(
      .CHUNK (CHUNK)
   ) u_slice (
      .x    (slice_a),
      .y    (slice_b),
      .mode (sub_reg),
      .bin  (bin),
      .d    (slice_d),
      .bout (slice_bout)
   );

   // Merge the freshly computed chunk into the accumulator image; on the final
   // chunk this is the complete result loaded into the output register.
   always_comb begin
      acc_nxt = acc;
      acc_nxt[base +: CHUNK] = slice_d;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; start outside IDLE is ignored, not queued.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture at acceptance, then one chunk per RUN edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg   <= '0;
         b_reg   <= '0;
         sub_reg <= 1'b0;
         idx     <= '0;
         bin     <= 1'b0;
         acc     <= '0;
      end else if (state == IDLE && bus.start) begin
         a_reg   <= bus.a;
         b_reg   <= bus.b;
         sub_reg <= bus.sub;
         idx     <= '0;
         bin     <= 1'b0;
         acc     <= '0;
      end else if (state == RUN) begin
         acc     <= acc_nxt;
         bin     <= slice_bout;
         idx     <= last ? '0 : idx + IDXW'(1);
      end
   end

   // Output registers change only on the edge that finishes the last chunk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_reg <= '0;
         brw_reg <= 1'b0;
         ovf_reg <= 1'b0;
      end else if (state == RUN && last) begin
         res_reg <= acc_nxt;
         brw_reg <= slice_bout;
         ovf_reg <= ovf_calc(sub_reg, a_reg[WIDTH-1], b_reg[WIDTH-1],
                             acc_nxt[WIDTH-1]);
      end
   end

   assign bus.ready    = (state == IDLE);
   assign bus.done     = (state == DONE);
   assign bus.result   = res_reg;
   assign bus.borrow   = brw_reg;
   assign bus.overflow = ovf_reg;

endmodule
